// File: rtl/rx_ts_align_if.sv
// ----------------------------------------------------------------------------
// rx_ts_align_if: MAC RX stream, timestamp strobe and aligned-output bundle.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface rx_ts_align_if #(
  parameter int AVST_DATA_WIDTH  = 128,
  parameter int AVST_EMPTY_WIDTH = 4,
  parameter int AVST_ERROR_WIDTH = 6,
  parameter int TS_WIDTH         = 96,
  parameter int TS_FIFO_DEPTH    = 4,
  parameter int CNT_WIDTH        = 16
);
  localparam int LW = $clog2(TS_FIFO_DEPTH) + 1;

  logic                        in_st_valid;
  logic                        in_st_sop;
  logic                        in_st_eop;
  logic [AVST_DATA_WIDTH-1:0]  in_st_data;
  logic [AVST_EMPTY_WIDTH-1:0] in_st_empty;
  logic [AVST_ERROR_WIDTH-1:0] in_st_error;
  logic                        in_ts_valid;
  logic [TS_WIDTH-1:0]         in_ts_data;

  logic                        out_st_valid;
  logic                        out_st_sop;
  logic                        out_st_eop;
  logic [AVST_DATA_WIDTH-1:0]  out_st_data;
  logic [AVST_EMPTY_WIDTH-1:0] out_st_empty;
  logic [AVST_ERROR_WIDTH-1:0] out_st_error;
  logic [TS_WIDTH-1:0]         out_ts_data;
  logic                        out_ts_miss;
  logic [CNT_WIDTH-1:0]        ts_drop_cnt;
  logic [CNT_WIDTH-1:0]        ts_miss_cnt;
  logic [CNT_WIDTH-1:0]        frame_err_cnt;
  logic [LW-1:0]               ts_fifo_level;

  modport master (
    output in_st_valid, in_st_sop, in_st_eop, in_st_data, in_st_empty,
           in_st_error, in_ts_valid, in_ts_data,
    input  out_st_valid, out_st_sop, out_st_eop, out_st_data, out_st_empty,
           out_st_error, out_ts_data, out_ts_miss, ts_drop_cnt, ts_miss_cnt,
           frame_err_cnt, ts_fifo_level
  );

  modport slave (
    input  in_st_valid, in_st_sop, in_st_eop, in_st_data, in_st_empty,
           in_st_error, in_ts_valid, in_ts_data,
    output out_st_valid, out_st_sop, out_st_eop, out_st_data, out_st_empty,
           out_st_error, out_ts_data, out_ts_miss, ts_drop_cnt, ts_miss_cnt,
           frame_err_cnt, ts_fifo_level
  );
endinterface

`default_nettype wire

// File: rtl/rx_ts_align.sv
// ----------------------------------------------------------------------------
// rx_ts_align: queues ingress timestamps and binds one to each RX packet sop.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rx_ts_align #(
  parameter int AVST_DATA_WIDTH  = 128,
  parameter int AVST_EMPTY_WIDTH = 4,
  parameter int AVST_ERROR_WIDTH = 6,
  parameter int TS_WIDTH         = 96,
  parameter int TS_FIFO_DEPTH    = 4,
  parameter int CNT_WIDTH        = 16
) (
  input  logic         in_st_clk,
  input  logic         in_st_rst_n,
  rx_ts_align_if.slave bus
);
  localparam int AW = $clog2(TS_FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [0:0]    ST_IDLE   = 1'b0;
  localparam logic [0:0]    ST_IN_PKT = 1'b1;
  localparam logic [LW-1:0] LVL_FULL  = LW'(TS_FIFO_DEPTH);

  logic [0:0]                  state_q, state_d;
  logic [TS_WIDTH-1:0]         mem_q [TS_FIFO_DEPTH];
  logic [TS_WIDTH-1:0]         mem_d [TS_FIFO_DEPTH];
  logic [AW-1:0]               rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]               level_q, level_d;
  logic                        valid_q, valid_d, sop_q, sop_d, eop_q, eop_d;
  logic [AVST_DATA_WIDTH-1:0]  data_q, data_d;
  logic [AVST_EMPTY_WIDTH-1:0] empty_q, empty_d;
  logic [AVST_ERROR_WIDTH-1:0] error_q, error_d;
  logic [TS_WIDTH-1:0]         ts_q, ts_d;
  logic                        miss_q, miss_d;
  logic [CNT_WIDTH-1:0]        drop_cnt_q, drop_cnt_d;
  logic [CNT_WIDTH-1:0]        miss_cnt_q, miss_cnt_d;
  logic [CNT_WIDTH-1:0]        ferr_cnt_q, ferr_cnt_d;

  logic acc_sop, acc_beat, frame_err, q_empty, q_full;
  logic pop, bypass, push_req, push, drop, miss;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c,
                                                   input logic en);
    return (en && !(&c)) ? c + CNT_WIDTH'(1) : c;
  endfunction

  always_comb begin
    acc_sop   = bus.in_st_valid & bus.in_st_sop;
    acc_beat  = bus.in_st_valid & (bus.in_st_sop | (state_q == ST_IN_PKT));
    frame_err = bus.in_st_valid &
                ((!bus.in_st_sop & (state_q == ST_IDLE)) |
                 ( bus.in_st_sop & (state_q == ST_IN_PKT)));
    q_empty   = (level_q == '0);
    q_full    = (level_q == LVL_FULL);
    pop       = acc_sop & !q_empty;
    // A strobe coinciding with an sop on an empty queue is consumed directly.
    bypass    = acc_sop & q_empty & bus.in_ts_valid;
    miss      = acc_sop & q_empty & !bus.in_ts_valid;
    push_req  = bus.in_ts_valid & !bypass;
    push      = push_req & (!q_full | pop);
    drop      = push_req & q_full & !pop;

    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = bus.in_ts_data;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q + LW'(push) - LW'(pop);

    state_d = state_q;
    if (acc_sop)                       state_d = bus.in_st_eop ? ST_IDLE : ST_IN_PKT;
    else if (acc_beat && bus.in_st_eop) state_d = ST_IDLE;

    valid_d = acc_beat;
    sop_d   = acc_sop;
    eop_d   = acc_beat & bus.in_st_eop;
    data_d  = bus.in_st_data;
    empty_d = bus.in_st_empty;
    error_d = bus.in_st_error;

    ts_d   = ts_q;
    miss_d = miss_q;
    if (acc_sop) begin
      ts_d   = pop ? mem_q[rd_ptr_q] : (bypass ? bus.in_ts_data : '0);
      miss_d = miss;
    end

    drop_cnt_d = sat_inc(drop_cnt_q, drop);
    miss_cnt_d = sat_inc(miss_cnt_q, miss);
    ferr_cnt_d = sat_inc(ferr_cnt_q, frame_err);
  end

  always_ff @(posedge in_st_clk) begin
    if (!in_st_rst_n) begin
      state_q    <= ST_IDLE;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      level_q    <= '0;
      valid_q    <= 1'b0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
      data_q     <= '0;
      empty_q    <= '0;
      error_q    <= '0;
      ts_q       <= '0;
      miss_q     <= 1'b0;
      drop_cnt_q <= '0;
      miss_cnt_q <= '0;
      ferr_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      level_q    <= level_d;
      valid_q    <= valid_d;
      sop_q      <= sop_d;
      eop_q      <= eop_d;
      data_q     <= data_d;
      empty_q    <= empty_d;
      error_q    <= error_d;
      ts_q       <= ts_d;
      miss_q     <= miss_d;
      drop_cnt_q <= drop_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      ferr_cnt_q <= ferr_cnt_d;
    end
  end

  // Storage needs no reset: the pointers and level define which entries are live.
  always_ff @(posedge in_st_clk) begin
    mem_q <= mem_d;
  end

  assign bus.out_st_valid  = valid_q;
  assign bus.out_st_sop    = sop_q;
  assign bus.out_st_eop    = eop_q;
  assign bus.out_st_data   = data_q;
  assign bus.out_st_empty  = empty_q;
  assign bus.out_st_error  = error_q;
  assign bus.out_ts_data   = ts_q;
  assign bus.out_ts_miss   = miss_q;
  assign bus.ts_drop_cnt   = drop_cnt_q;
  assign bus.ts_miss_cnt   = miss_cnt_q;
  assign bus.frame_err_cnt = ferr_cnt_q;
  assign bus.ts_fifo_level = level_q;
endmodule

`default_nettype wire

// File: tb/tb_rx_ts_align.sv
// ----------------------------------------------------------------------------
// tb_rx_ts_align: directed self-checking bench for rx_ts_align.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_rx_ts_align;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests_run = 0;
  int tests_failed = 0;

  localparam logic [95:0] TA = 96'hA0A0_0000_0000_0000_0000_00A1;
  localparam logic [95:0] TB = 96'hB0B0_0000_0000_0000_0000_00B1;
  localparam logic [95:0] TC = 96'hC0C0_0000_0000_0000_0000_00C1;
  localparam logic [95:0] TD = 96'hD0D0_0000_0000_0000_0000_00D1;
  localparam logic [95:0] TE = 96'hE0E0_0000_0000_0000_0000_00E1;

  always #5 clk = ~clk;

  rx_ts_align_if #(.CNT_WIDTH(CW)) bus ();
  rx_ts_align #(.CNT_WIDTH(CW)) dut (.in_st_clk(clk), .in_st_rst_n(rst_n), .bus(bus));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic v, input logic s, input logic e,
                      input logic [127:0] d, input logic [3:0] emp);
    bus.in_st_valid = v; bus.in_st_sop = s; bus.in_st_eop = e;
    bus.in_st_data = d; bus.in_st_empty = emp; bus.in_st_error = 6'h0;
  endtask

  task automatic ts(input logic v, input logic [95:0] t);
    bus.in_ts_valid = v; bus.in_ts_data = t;
  endtask

  task automatic do_reset();
    beat(0, 0, 0, '0, '0); ts(0, '0);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
  endtask

  task automatic test_reset();
    beat(1, 1, 0, 128'h55, 4'h0); ts(1, TA);
    rst_n = 1'b0; tick(); tick();
    tests_run++; if (bus.out_st_valid !== 1'b0 || bus.out_st_sop !== 1'b0 || bus.out_st_eop !== 1'b0) begin tests_failed++; $display("FAIL reset_qual got v%b s%b e%b exp 000", bus.out_st_valid, bus.out_st_sop, bus.out_st_eop); end
    tests_run++; if (bus.out_ts_data !== 96'h0 || bus.out_ts_miss !== 1'b0) begin tests_failed++; $display("FAIL reset_ts got %h/%b exp 0/0", bus.out_ts_data, bus.out_ts_miss); end
    tests_run++; if (bus.ts_drop_cnt !== 8'h0 || bus.ts_miss_cnt !== 8'h0 || bus.frame_err_cnt !== 8'h0) begin tests_failed++; $display("FAIL reset_cnt got %h %h %h exp 0 0 0", bus.ts_drop_cnt, bus.ts_miss_cnt, bus.frame_err_cnt); end
    tests_run++; if (bus.ts_fifo_level !== 3'd0) begin tests_failed++; $display("FAIL reset_level got %0d exp 0", bus.ts_fifo_level); end
    beat(0, 0, 0, '0, '0); ts(0, '0); rst_n = 1'b1; tick();
    tests_run++; if (bus.ts_fifo_level !== 3'd0) begin tests_failed++; $display("FAIL reset_ts_ignored level got %0d exp 0", bus.ts_fifo_level); end
  endtask

  task automatic test_basic();
    do_reset();
    ts(1, TA); tick(); ts(0, '0);
    tests_run++; if (bus.ts_fifo_level !== 3'd1) begin tests_failed++; $display("FAIL basic_push level got %0d exp 1", bus.ts_fifo_level); end
    tick();
    beat(1, 1, 0, 128'h100, 4'h0); tick();
    tests_run++; if (bus.out_st_valid !== 1'b1 || bus.out_st_sop !== 1'b1 || bus.out_st_eop !== 1'b0 || bus.out_st_data !== 128'h100) begin tests_failed++; $display("FAIL basic_sop got v%b s%b e%b d%h exp v1 s1 e0 d100", bus.out_st_valid, bus.out_st_sop, bus.out_st_eop, bus.out_st_data); end
    tests_run++; if (bus.out_ts_data !== TA || bus.out_ts_miss !== 1'b0 || bus.ts_fifo_level !== 3'd0) begin tests_failed++; $display("FAIL basic_sop_ts got %h/%b/%0d exp %h/0/0", bus.out_ts_data, bus.out_ts_miss, bus.ts_fifo_level, TA); end
    beat(1, 0, 0, 128'h101, 4'h0); tick();
    tests_run++; if (bus.out_st_valid !== 1'b1 || bus.out_st_sop !== 1'b0 || bus.out_st_data !== 128'h101 || bus.out_ts_data !== TA) begin tests_failed++; $display("FAIL basic_mid got v%b s%b d%h ts%h exp v1 s0 d101 ts%h", bus.out_st_valid, bus.out_st_sop, bus.out_st_data, bus.out_ts_data, TA); end
    beat(1, 0, 1, 128'h102, 4'h3); tick();
    tests_run++; if (bus.out_st_valid !== 1'b1 || bus.out_st_eop !== 1'b1 || bus.out_st_empty !== 4'h3 || bus.out_ts_data !== TA) begin tests_failed++; $display("FAIL basic_eop got v%b e%b emp%h ts%h exp v1 e1 emp3 ts%h", bus.out_st_valid, bus.out_st_eop, bus.out_st_empty, bus.out_ts_data, TA); end
    beat(0, 0, 0, '0, '0); tick();
    tests_run++; if (bus.out_st_valid !== 1'b0 || bus.out_ts_data !== TA) begin tests_failed++; $display("FAIL basic_hold got v%b ts%h exp v0 ts%h", bus.out_st_valid, bus.out_ts_data, TA); end
  endtask

  task automatic test_bypass();
    do_reset();
    beat(1, 1, 1, 128'h200, 4'h1); ts(1, TB); tick();
    beat(0, 0, 0, '0, '0); ts(0, '0);
    tests_run++; if (bus.out_st_sop !== 1'b1 || bus.out_st_eop !== 1'b1 || bus.out_ts_data !== TB || bus.out_ts_miss !== 1'b0) begin tests_failed++; $display("FAIL bypass got s%b e%b ts%h m%b exp s1 e1 ts%h m0", bus.out_st_sop, bus.out_st_eop, bus.out_ts_data, bus.out_ts_miss, TB); end
    tests_run++; if (bus.ts_fifo_level !== 3'd0) begin tests_failed++; $display("FAIL bypass_level got %0d exp 0", bus.ts_fifo_level); end
    tick();
    tests_run++; if (bus.ts_fifo_level !== 3'd0) begin tests_failed++; $display("FAIL bypass_level_after got %0d exp 0", bus.ts_fifo_level); end
  endtask

  task automatic test_overflow();
    logic [95:0] exp_ts [5];
    do_reset();
    for (int i = 0; i < 5; i++) begin ts(1, 96'hF00 + 96'(i)); tick(); end
    ts(0, '0);
    tests_run++; if (bus.ts_drop_cnt !== 8'd1 || bus.ts_fifo_level !== 3'd4) begin tests_failed++; $display("FAIL ovf_drop got drop%0d lvl%0d exp drop1 lvl4", bus.ts_drop_cnt, bus.ts_fifo_level); end
    beat(1, 1, 1, 128'h300, 4'h0); ts(1, 96'hF05); tick(); ts(0, '0);
    tests_run++; if (bus.out_ts_data !== 96'hF00 || bus.ts_fifo_level !== 3'd4 || bus.ts_drop_cnt !== 8'd1) begin tests_failed++; $display("FAIL ovf_pushpop got ts%h lvl%0d drop%0d exp ts f00 lvl4 drop1", bus.out_ts_data, bus.ts_fifo_level, bus.ts_drop_cnt); end
    exp_ts[0] = 96'hF01; exp_ts[1] = 96'hF02; exp_ts[2] = 96'hF03; exp_ts[3] = 96'hF05;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests_run++; if (bus.out_ts_data !== exp_ts[i] || bus.out_st_sop !== 1'b1) begin tests_failed++; $display("FAIL ovf_pkt%0d got ts%h s%b exp ts%h s1", i + 1, bus.out_ts_data, bus.out_st_sop, exp_ts[i]); end
    end
    beat(0, 0, 0, '0, '0); tick();
    tests_run++; if (bus.ts_fifo_level !== 3'd0 || bus.ts_miss_cnt !== 8'd0) begin tests_failed++; $display("FAIL ovf_end got lvl%0d miss%0d exp 0 0", bus.ts_fifo_level, bus.ts_miss_cnt); end
  endtask

  task automatic test_miss();
    do_reset();
    beat(1, 1, 0, 128'h400, 4'h0); tick();
    tests_run++; if (bus.out_ts_data !== 96'h0 || bus.out_ts_miss !== 1'b1 || bus.ts_miss_cnt !== 8'd1) begin tests_failed++; $display("FAIL miss_sop got ts%h m%b cnt%0d exp 0 1 1", bus.out_ts_data, bus.out_ts_miss, bus.ts_miss_cnt); end
    beat(1, 0, 1, 128'h401, 4'h0); tick();
    tests_run++; if (bus.out_ts_data !== 96'h0 || bus.out_ts_miss !== 1'b1 || bus.out_st_eop !== 1'b1) begin tests_failed++; $display("FAIL miss_eop got ts%h m%b e%b exp 0 1 1", bus.out_ts_data, bus.out_ts_miss, bus.out_st_eop); end
    beat(0, 0, 0, '0, '0); ts(1, TC); tick(); ts(0, '0);
    tests_run++; if (bus.out_ts_miss !== 1'b1) begin tests_failed++; $display("FAIL miss_hold got %b exp 1", bus.out_ts_miss); end
    beat(1, 1, 1, 128'h402, 4'h0); tick(); beat(0, 0, 0, '0, '0);
    tests_run++; if (bus.out_ts_miss !== 1'b0 || bus.out_ts_data !== TC || bus.ts_miss_cnt !== 8'd1) begin tests_failed++; $display("FAIL miss_clear got m%b ts%h cnt%0d exp 0 %h 1", bus.out_ts_miss, bus.out_ts_data, bus.ts_miss_cnt, TC); end
  endtask

  task automatic test_framing();
    do_reset();
    beat(1, 0, 0, 128'h500, 4'h0); tick();
    tests_run++; if (bus.out_st_valid !== 1'b0 || bus.frame_err_cnt !== 8'd1) begin tests_failed++; $display("FAIL frm_orphan got v%b ferr%0d exp 0 1", bus.out_st_valid, bus.frame_err_cnt); end
    beat(0, 0, 0, '0, '0); ts(1, TD); tick(); ts(0, '0);
    beat(1, 1, 0, 128'h501, 4'h0); tick();
    beat(1, 0, 0, 128'h502, 4'h0); ts(1, TE); tick(); ts(0, '0);
    beat(1, 1, 0, 128'h503, 4'h0); tick();
    tests_run++; if (bus.out_st_sop !== 1'b1 || bus.out_st_valid !== 1'b1 || bus.out_ts_data !== TE || bus.frame_err_cnt !== 8'd2) begin tests_failed++; $display("FAIL frm_resop got s%b v%b ts%h ferr%0d exp 1 1 %h 2", bus.out_st_sop, bus.out_st_valid, bus.out_ts_data, bus.frame_err_cnt, TE); end
    beat(1, 0, 0, 128'h504, 4'h0); tick();
    rst_n = 1'b0; tick();
    tests_run++; if (bus.out_st_valid !== 1'b0 || bus.out_st_sop !== 1'b0 || bus.out_st_eop !== 1'b0 || bus.out_ts_data !== 96'h0 || bus.out_ts_miss !== 1'b0) begin tests_failed++; $display("FAIL frm_rst_out got v%b s%b e%b ts%h m%b exp all 0", bus.out_st_valid, bus.out_st_sop, bus.out_st_eop, bus.out_ts_data, bus.out_ts_miss); end
    tests_run++; if (bus.frame_err_cnt !== 8'd0 || bus.ts_fifo_level !== 3'd0) begin tests_failed++; $display("FAIL frm_rst_state got ferr%0d lvl%0d exp 0 0", bus.frame_err_cnt, bus.ts_fifo_level); end
    rst_n = 1'b1; beat(1, 0, 1, 128'h505, 4'h0); tick(); beat(0, 0, 0, '0, '0);
    tests_run++; if (bus.out_st_valid !== 1'b0 || bus.out_st_eop !== 1'b0 || bus.frame_err_cnt !== 8'd1) begin tests_failed++; $display("FAIL frm_post_rst got v%b e%b ferr%0d exp 0 0 1", bus.out_st_valid, bus.out_st_eop, bus.frame_err_cnt); end
  endtask

  task automatic test_saturation();
    do_reset();
    beat(1, 1, 1, 128'h600, 4'h0);
    for (int i = 0; i < (1 << CW) + 3; i++) tick();
    beat(0, 0, 0, '0, '0); tick();
    tests_run++; if (bus.ts_miss_cnt !== {CW{1'b1}}) begin tests_failed++; $display("FAIL sat_miss got %h exp %h", bus.ts_miss_cnt, {CW{1'b1}}); end
  endtask

  initial begin
    beat(0, 0, 0, '0, '0); ts(0, '0);
    test_reset();
    test_basic();
    test_bypass();
    test_overflow();
    test_miss();
    test_framing();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/rx_ts_align.md
RX_TS_ALIGN -- requirements
Module: rx_ts_align

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- AVST_DATA_WIDTH, 128, packet data width.
- AVST_EMPTY_WIDTH, 4, empty-byte count width.
- AVST_ERROR_WIDTH, 6, error width.
- TS_WIDTH, 96, ingress timestamp width.
- TS_FIFO_DEPTH, 4, timestamp queue entries; power of two, at least 2.
- CNT_WIDTH, 16, width of each statistics counter.

REQ-002 Ports (name, direction, width, meaning), one per line:
- in_st_clk, in, 1, sole clock.
- in_st_rst_n, in, 1, reset; synchronous, active-low.
- in_st_valid / in_st_sop / in_st_eop, in, 1 each, MAC RX AVST beat qualifiers.
- in_st_data, in, AVST_DATA_WIDTH, beat data.
- in_st_empty, in, AVST_EMPTY_WIDTH, empty bytes; meaningful only on eop.
- in_st_error, in, AVST_ERROR_WIDTH, beat error.
- in_ts_valid, in, 1, ingress timestamp strobe; one per packet, arrives at or before that packet's sop.
- in_ts_data, in, TS_WIDTH, ingress timestamp.
- out_st_valid / out_st_sop / out_st_eop, out, 1 each, aligned beat qualifiers.
- out_st_data / out_st_empty / out_st_error, out, as inputs, aligned beat.
- out_ts_data, out, TS_WIDTH, timestamp bound to the current packet; held from sop through eop.
- out_ts_miss, out, 1, high for the whole packet when no timestamp was available at its sop.
- ts_drop_cnt, out, CNT_WIDTH, timestamps discarded because the queue was full.
- ts_miss_cnt, out, CNT_WIDTH, packets started with no timestamp.
- frame_err_cnt, out, CNT_WIDTH, framing violations.
- ts_fifo_level, out, clog2(TS_FIFO_DEPTH)+1, queue occupancy.

REQ-003 There is no ready or backpressure port; the stream is always accepted.

Function
REQ-004 Pipeline: all out_st_* and out_ts_* outputs are registered, with exactly 1 cycle latency from the input beat.

REQ-005 Timestamp queue: FIFO with TS_FIFO_DEPTH entries.
- Push when in_ts_valid=1.
- Pop when an accepted sop finds the queue non-empty.

REQ-006 Timestamp selection at an accepted sop:
- Queue non-empty: use the queue head.
- Queue empty and in_ts_valid=1 in the same cycle: bypass; use in_ts_data and do not push it.
- Otherwise: use all zeros, set out_ts_miss=1, and increment ts_miss_cnt.

REQ-007 Full queue:
- Push without a pop: discard the incoming timestamp and increment ts_drop_cnt.
- Push and pop in the same cycle: accept both; level is unchanged.

REQ-008 State machine has states IDLE and IN_PKT.
- IDLE to IN_PKT: valid & sop & !eop.
- IDLE with valid & sop & eop: single-beat packet; forwarded, state stays IDLE.
- IN_PKT to IDLE: valid & eop.

REQ-009 Beat acceptance:
- A valid beat without sop in IDLE is dropped (out_st_valid=0) and increments frame_err_cnt.
- A sop in IN_PKT is forwarded as a new packet; the previous packet's eop is not synthesised.
- In that case frame_err_cnt increments and a new timestamp is selected per REQ-006.

REQ-010 out_ts_data and out_ts_miss:
- Update only on the output sop beat.
- Hold until the next output sop, including idle gaps.

REQ-011 Counters saturate at all ones and never wrap.

REQ-012 Beats with in_st_valid=0 produce out_st_valid=0. out_st_data, empty and error are don't-care when out_st_valid=0.

Reset
REQ-013 While in_st_rst_n=0 at a clock edge, on the next edge:
- State is IDLE and the queue is empty (level 0).
- All counters are 0.
- out_st_valid, sop and eop are 0.
- out_ts_data is 0 and out_ts_miss is 0.

REQ-014 Reset asserted mid-packet discards the partial packet; no eop is emitted. After reset, the first beat is accepted only if it carries sop.

REQ-015 in_ts_valid during reset is ignored.

Verification
REQ-016 Basic alignment: ts=A at cycle 0; 3-beat packet with sop at cycle 2.
- Outputs appear at cycles 3-5.
- out_ts_data=A throughout; out_ts_miss=0; level returns to 0.

REQ-017 Bypass: in_ts_valid=B in the same cycle as a single-beat sop, with an empty queue.
- Next cycle: sop=eop=1, out_ts_data=B.
- Level stays 0.

REQ-018 Overflow: 5 timestamps T0-T4 with no packets, then 4 packets.
- ts_drop_cnt=1.
- Packets carry T0, T1, T2, T3.

REQ-019 Miss: packet with an empty queue and no strobe.
- out_ts_data=0 and out_ts_miss=1 for every beat; ts_miss_cnt=1.
- A following packet with a timestamp clears out_ts_miss.

REQ-020 Framing and reset:
- Orphan mid-beat in IDLE: dropped; frame_err_cnt=1.
- sop inside a packet: new packet started; frame_err_cnt=2.
- in_st_rst_n=0 mid-packet: all REQ-013 values reached; the next non-sop beat is dropped.

REQ-021 Saturation: force 2^CNT_WIDTH+3 misses; ts_miss_cnt holds at all ones.
